// File: rtl/ins_fetch_queue.sv
// Instruction fetch queue: owns the fetch PC, issues one fetch at a time, statically
// decodes control flow (BHT-predicted branches) and buffers entries for dispatch.
module ins_fetch_queue #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             Clear_flag,
  input  logic             ROB_to_insqueue_needchange,
  input  logic [31:0]      pc_,
  output logic             fetch_req,
  output logic [31:0]      fetch_pc,
  input  logic             fetch_done,
  input  logic [31:0]      fetch_inst,
  output logic [11:0]      bht_id,
  input  logic             bht_taken,
  output logic             deq_valid,
  output logic [31:0]      deq_pc,
  output logic [31:0]      deq_inst,
  output logic             deq_isjump,
  output logic [31:0]      deq_jumppc,
  input  logic             deq_ready,
  output logic [PTR_W:0]   count
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DROP = 2'd2} fsm_e;

  localparam logic [PTR_W:0] FULL      = (PTR_W+1)'(DEPTH);
  localparam logic [6:0]     OP_JAL    = 7'b1101111;
  localparam logic [6:0]     OP_BRANCH = 7'b1100011;

  fsm_e             state_q, state_d;
  logic             fetch_req_d;
  logic [31:0]      fetch_pc_d;
  logic [31:0]      pc_q, pc_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   count_d, count_after_deq;
  logic             enq, deq;

  logic [31:0] mem_pc     [DEPTH];
  logic [31:0] mem_inst   [DEPTH];
  logic        mem_isjump [DEPTH];
  logic [31:0] mem_jumppc [DEPTH];

  logic [31:0] imm_j, imm_b, dec_jumppc, dec_next;
  logic        dec_isjump;

  assign bht_id = fetch_inst[11:0];

  // JALR and every other opcode fall through: not predicted, next PC is pc+4.
  always_comb begin
    imm_j      = {{12{fetch_inst[31]}}, fetch_inst[19:12], fetch_inst[20],
                  fetch_inst[30:21], 1'b0};
    imm_b      = {{20{fetch_inst[31]}}, fetch_inst[7], fetch_inst[30:25],
                  fetch_inst[11:8], 1'b0};
    dec_isjump = 1'b0;
    dec_jumppc = '0;
    dec_next   = fetch_pc + 32'd4;
    case (fetch_inst[6:0])
      OP_JAL: begin
        dec_isjump = 1'b1;
        dec_jumppc = fetch_pc + imm_j;
        dec_next   = dec_jumppc;
      end
      OP_BRANCH: begin
        dec_isjump = bht_taken;
        dec_jumppc = fetch_pc + imm_b;
        if (bht_taken) dec_next = dec_jumppc;
      end
      default: ;
    endcase
  end

  // Handshake: the head transfers on a cycle with rdy && deq_valid && deq_ready;
  // fetch_req stays high until the one-cycle fetch_done pulse retires it.
  always_comb begin
    state_d         = state_q;
    fetch_req_d     = fetch_req;
    fetch_pc_d      = fetch_pc;
    pc_d            = pc_q;
    head_d          = head_q;
    tail_d          = tail_q;
    enq             = 1'b0;
    deq             = deq_ready && deq_valid && !Clear_flag;
    count_after_deq = count - {{PTR_W{1'b0}}, deq};
    case (state_q)
      IDLE: begin
        if (!Clear_flag && (count_after_deq < FULL)) begin
          state_d     = BUSY;
          fetch_req_d = 1'b1;
          fetch_pc_d  = pc_q;
        end
      end
      BUSY: begin
        if (fetch_done) begin
          state_d     = IDLE;
          fetch_req_d = 1'b0;
          if (!Clear_flag) begin
            enq  = 1'b1;
            pc_d = dec_next;
          end
        end else if (Clear_flag) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (fetch_done) begin
          state_d     = IDLE;
          fetch_req_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (deq) head_d = head_q + PTR_W'(1);
    if (enq) tail_d = tail_q + PTR_W'(1);
    count_d = count_after_deq + {{PTR_W{1'b0}}, enq};
    // A flush wipes the queue and overrides any dequeue or enqueue this cycle.
    if (Clear_flag) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      if (ROB_to_insqueue_needchange) pc_d = pc_;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      fetch_req <= 1'b0;
      fetch_pc  <= '0;
      pc_q      <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count     <= '0;
    end else if (rdy) begin
      state_q   <= state_d;
      fetch_req <= fetch_req_d;
      fetch_pc  <= fetch_pc_d;
      pc_q      <= pc_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count     <= count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]     <= '0;
        mem_inst[i]   <= '0;
        mem_isjump[i] <= 1'b0;
        mem_jumppc[i] <= '0;
      end
    end else if (rdy && enq) begin
      mem_pc[tail_q]     <= fetch_pc;
      mem_inst[tail_q]   <= fetch_inst;
      mem_isjump[tail_q] <= dec_isjump;
      mem_jumppc[tail_q] <= dec_jumppc;
    end
  end

  assign deq_valid  = (count != '0);
  assign deq_pc     = mem_pc[head_q];
  assign deq_inst   = mem_inst[head_q];
  assign deq_isjump = mem_isjump[head_q];
  assign deq_jumppc = mem_jumppc[head_q];

endmodule

// File: tb/tb_ins_fetch_queue.sv
// Bench for ins_fetch_queue: directed scenarios plus randomized traffic, checked
// against a queue-based reference model of fetch, decode and dispatch.
module tb_ins_fetch_queue;

  localparam int DEPTH = 16;
  localparam int PTR_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             rdy = 1'b1;
  logic             Clear_flag = 1'b0;
  logic             ROB_to_insqueue_needchange = 1'b0;
  logic [31:0]      pc_ = '0;
  logic             fetch_req;
  logic [31:0]      fetch_pc;
  logic             fetch_done = 1'b0;
  logic [31:0]      fetch_inst = 32'h13;
  logic [11:0]      bht_id;
  logic             bht_taken;
  logic             deq_valid;
  logic [31:0]      deq_pc;
  logic [31:0]      deq_inst;
  logic             deq_isjump;
  logic [31:0]      deq_jumppc;
  logic             deq_ready = 1'b0;
  logic [PTR_W:0]   count;

  ins_fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .Clear_flag(Clear_flag), .ROB_to_insqueue_needchange(ROB_to_insqueue_needchange),
    .pc_(pc_), .fetch_req(fetch_req), .fetch_pc(fetch_pc),
    .fetch_done(fetch_done), .fetch_inst(fetch_inst),
    .bht_id(bht_id), .bht_taken(bht_taken),
    .deq_valid(deq_valid), .deq_pc(deq_pc), .deq_inst(deq_inst),
    .deq_isjump(deq_isjump), .deq_jumppc(deq_jumppc),
    .deq_ready(deq_ready), .count(count)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // bench-side BHT: 0 = never taken, 1 = always taken, 2 = hashed
  logic [1:0] bht_mode = 2'd2;

  function automatic logic bht_model(input logic [11:0] id);
    return (bht_mode == 2'd2) ? (id[2] ^ id[9]) : bht_mode[0];
  endfunction

  always_comb bht_taken = bht_model(bht_id);

  // scoreboard: {pc, inst, isjump, jumppc}
  logic [96:0] exp_q[$];
  logic        m_req;
  logic        m_drop;
  logic [31:0] m_pc;
  logic [31:0] m_fetch_pc;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    exp_q.delete();
    m_req      = 1'b0;
    m_drop     = 1'b0;
    m_pc       = '0;
    m_fetch_pc = '0;
  endfunction

  function automatic void decode(input logic [31:0] pc, input logic [31:0] inst,
                                 output logic [96:0] e, output logic [31:0] nxt);
    logic [31:0] imm;
    logic [31:0] tgt;
    logic        j;
    nxt = pc + 32'd4;
    tgt = '0;
    j   = 1'b0;
    if (inst[6:0] == 7'h6F) begin
      imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      tgt = pc + imm;
      j   = 1'b1;
      nxt = tgt;
    end else if (inst[6:0] == 7'h63) begin
      imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      tgt = pc + imm;
      j   = bht_model(inst[11:0]);
      if (j) nxt = tgt;
    end
    e = {pc, inst, j, tgt};
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 4))
      0: return {r[31:7], 7'h6F};
      1: return {r[31:7], 7'h63};
      2: return {r[31:7], 7'h67};
      3: return {r[31:7], 7'h13};
      default: return r;
    endcase
  endfunction

  task automatic check_all();
    logic [96:0] e;
    check("fetch_req", 32'(fetch_req), 32'(m_req));
    if (m_req) check("fetch_pc", fetch_pc, m_fetch_pc);
    check("count", 32'(count), 32'(exp_q.size()));
    check("deq_valid", 32'(deq_valid), 32'(exp_q.size() != 0));
    check("bht_id", 32'(bht_id), 32'(fetch_inst[11:0]));
    if (exp_q.size() != 0) begin
      e = exp_q[0];
      check("deq_pc", deq_pc, e[96:65]);
      check("deq_inst", deq_inst, e[64:33]);
      check("deq_isjump", 32'(deq_isjump), 32'(e[32]));
      check("deq_jumppc", deq_jumppc, e[31:0]);
    end
  endtask

  // driver: called at a falling edge, drives one cycle, updates the model, checks
  task automatic step(input logic r, input logic fd, input logic [31:0] fi,
                      input logic dr, input logic cf, input logic nc,
                      input logic [31:0] np);
    logic [96:0] e;
    logic [31:0] nxt;
    rdy = r;
    fetch_done = fd;
    fetch_inst = fi;
    deq_ready = dr;
    Clear_flag = cf;
    ROB_to_insqueue_needchange = nc;
    pc_ = np;
    if (r) begin
      if (dr && !cf && exp_q.size() != 0) void'(exp_q.pop_front());
      if (m_req && fd) begin
        if (!m_drop && !cf) begin
          decode(m_fetch_pc, fi, e, nxt);
          exp_q.push_back(e);
          m_pc = nxt;
        end
        m_req  = 1'b0;
        m_drop = 1'b0;
      end else if (m_req) begin
        if (cf) m_drop = 1'b1;
      end else if (!cf && exp_q.size() < DEPTH) begin
        m_req      = 1'b1;
        m_fetch_pc = m_pc;
      end
      if (cf) begin
        exp_q.delete();
        if (nc) m_pc = np;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_step();
    step(1'b1, 1'b0, 32'h13, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic done_step(input logic [31:0] inst);
    step(1'b1, 1'b1, inst, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic flush_step(input logic fd, input logic dr, input logic [31:0] target);
    step(1'b1, fd, 32'h13, dr, 1'b1, 1'b1, target);
  endtask

  initial begin
    logic r, fd, dr, cf, nc;
    int   dr_bias;
    model_reset();

    // reset state
    repeat (2) @(negedge clk);
    check("rst_fetch_req", 32'(fetch_req), 32'h0);
    check("rst_fetch_pc", fetch_pc, 32'h0);
    check("rst_deq_valid", 32'(deq_valid), 32'h0);
    check("rst_count", 32'(count), 32'h0);
    check("rst_deq_pc", deq_pc, 32'h0);
    check("rst_deq_inst", deq_inst, 32'h0);
    check("rst_deq_isjump", 32'(deq_isjump), 32'h0);
    check("rst_deq_jumppc", deq_jumppc, 32'h0);
    rst = 1'b0;

    // addi at pc 0
    idle_step();
    check("req_after_reset", 32'(fetch_req), 32'h1);
    done_step(32'h00100093);
    check("addi_valid", 32'(deq_valid), 32'h1);
    check("addi_pc", deq_pc, 32'h0);
    check("addi_isjump", 32'(deq_isjump), 32'h0);
    check("addi_jumppc", deq_jumppc, 32'h0);
    check("addi_req_low", 32'(fetch_req), 32'h0);
    idle_step();
    check("addi_next_pc", fetch_pc, 32'h4);

    // flush coincident with fetch_done and deq_ready
    flush_step(1'b1, 1'b1, 32'h10);
    check("flush_done_count", 32'(count), 32'h0);
    check("flush_done_req", 32'(fetch_req), 32'h0);
    idle_step();
    check("flush_done_pc", fetch_pc, 32'h10);

    // jal +8 at 0x10
    done_step(32'h0080006F);
    check("jal_isjump", 32'(deq_isjump), 32'h1);
    check("jal_jumppc", deq_jumppc, 32'h18);
    idle_step();
    check("jal_next_pc", fetch_pc, 32'h18);

    // flush while busy, response arrives two cycles later and is dropped
    flush_step(1'b0, 1'b0, 32'h20);
    check("drop_count", 32'(count), 32'h0);
    check("drop_req_held", 32'(fetch_req), 32'h1);
    idle_step();
    idle_step();
    done_step(32'h0080006F);
    check("drop_discard", 32'(count), 32'h0);
    idle_step();
    check("redirect_20", fetch_pc, 32'h20);

    // beq -4 predicted taken
    bht_mode = 2'd1;
    done_step(32'hFE000EE3);
    check("beq_t_isjump", 32'(deq_isjump), 32'h1);
    check("beq_t_jumppc", deq_jumppc, 32'h1C);
    idle_step();
    check("beq_t_next", fetch_pc, 32'h1C);

    // same branch predicted not taken
    flush_step(1'b0, 1'b1, 32'h20);
    done_step(32'h13);
    idle_step();
    bht_mode = 2'd0;
    done_step(32'hFE000EE3);
    check("beq_nt_isjump", 32'(deq_isjump), 32'h0);
    check("beq_nt_jumppc", deq_jumppc, 32'h1C);
    idle_step();
    check("beq_nt_next", fetch_pc, 32'h24);

    // flush to 0x100 while busy, late response
    flush_step(1'b0, 1'b0, 32'h100);
    idle_step();
    idle_step();
    done_step(32'h13);
    check("f100_count", 32'(count), 32'h0);
    idle_step();
    check("f100_pc", fetch_pc, 32'h100);

    // rdy low mid-request: everything frozen, fetch_done ignored
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 32'h0080006F, 1'b1, 1'b0, 1'b0, '0);
      check("frozen_req", 32'(fetch_req), 32'h1);
      check("frozen_pc", fetch_pc, 32'h100);
      check("frozen_count", 32'(count), 32'h0);
    end
    done_step(32'h13);
    check("thaw_pc", deq_pc, 32'h100);

    // fill to full, then one dequeue reopens a slot
    bht_mode = 2'd2;
    flush_step(1'b0, 1'b0, 32'h200);
    for (int i = 0; i < 100 && exp_q.size() < DEPTH; i++)
      step(1'b1, m_req, rand_inst(), 1'b0, 1'b0, 1'b0, '0);
    check("full_count", 32'(count), 32'(DEPTH));
    for (int i = 0; i < 3; i++) begin
      idle_step();
      check("full_no_req", 32'(fetch_req), 32'h0);
    end
    step(1'b1, 1'b0, 32'h13, 1'b1, 1'b0, 1'b0, '0);
    check("reopen_count", 32'(count), 32'(DEPTH - 1));
    check("reopen_req", 32'(fetch_req), 32'h1);
    done_step(rand_inst());
    check("refill_count", 32'(count), 32'(DEPTH));
    for (int i = 0; i < 50; i++)
      step(1'b1, m_req && ($urandom_range(0, 1) == 0), rand_inst(), 1'b1, 1'b0, 1'b0, '0);

    // reset in the middle of a request
    for (int i = 0; i < 4 && !m_req; i++) idle_step();
    check("pre_reset_req", 32'(fetch_req), 32'h1);
    rst = 1'b1;
    #1;
    check("async_rst_req", 32'(fetch_req), 32'h0);
    check("async_rst_count", 32'(count), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // randomized traffic
    dr_bias = 2;
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) dr_bias = $urandom_range(0, 4);
      r  = ($urandom_range(0, 9) != 0);
      fd = m_req && ($urandom_range(0, 2) == 0);
      dr = ($urandom_range(0, 3) < dr_bias);
      cf = ($urandom_range(0, 59) == 0);
      nc = cf && ($urandom_range(0, 3) != 0);
      step(r, fd, rand_inst(), dr, cf, nc, $urandom & 32'hFFFF_FFFC);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
